mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory stage of the 5-stage RV32I pipeline. Consumes EX/MEM register outputs, drives the data-memory req/ack port, and stalls upstream while an access is outstanding.
//  Aligns store data/byte-enables, sign/zero-extends load data, and owns the MEM/WB pipeline register.
// PARAMETERS
//  XLEN         32   datapath width
//  ACK_TIMEOUT  16   max WAIT cycles before abort; 0 = never time out
// PORTS
//  clk               in   1     clock
//  rst               in   1     async reset, active-high
//  ex_mem_instr      in   32    instruction (opcode[6:0], funct3[14:12])
//  ex_mem_ALUOut     in   32    effective address / ALU result
//  ex_mem_rs2_data   in   32    store data
//  ex_mem_pc         in   32    PC of instruction
//  ex_mem_mem_to_reg in   2     00 ALU, 01 load, 10 PC+4
//  ex_mem_regWrite   in   1     register write enable
//  ex_mem_rd         in   5     destination register
//  dmem_req          out  1     access request, held until ack
//  dmem_we           out  1     1 store, 0 load
//  dmem_addr         out  32    word address ({addr[31:2],2'b00})
//  dmem_be           out  4     byte enables
//  dmem_wdata        out  32    lane-aligned store data
//  dmem_ack          in   1     access complete; rdata valid same cycle
//  dmem_rdata        in   32    read word
//  mem_stall         out  1     hold EX/MEM and earlier stages
//  dmem_timeout      out  1     1-cycle pulse on timeout abort
//  mem_wb_alu_out    out  32    registered ALUOut
//  mem_wb_load_data  out  32    registered extended load result
//  mem_wb_pc         out  32    registered PC
//  mem_wb_mem_to_reg out  2     registered mem_to_reg
//  mem_wb_regWrite   out  1     registered write enable
//  mem_wb_rd         out  5     registered rd
// BEHAVIOUR
//  - Load: opcode 0000011, funct3 LB000 LH001 LW010 LBU100 LHU101. Store: opcode 0100011, SB000 SH001 SW010.
//  - FSM IDLE/WAIT. IDLE + mem op: dmem_req=1 combinationally; ack same cycle -> complete (0 wait); else -> WAIT.
//  - WAIT: hold req/we/addr/be/wdata stable until ack, then -> IDLE. Counter increments each WAIT cycle; at ACK_TIMEOUT -> IDLE, dmem_timeout pulse, instruction retired as bubble.
//  - mem_stall = mem op && !dmem_ack && !timeout (combinational). Non-mem ops never stall.
//  - MEM/WB captures every cycle. Stalled cycle: bubble written (regWrite=0, rd=0, mem_to_reg=0, data fields 0).
//  - Store lanes: SB be=1<<a[1:0], byte replicated x4. SH be=a[1]?1100:0011, half replicated x2. SW be=1111.
//  - Load extract: byte lane a[1:0], half lane a[1]. LB/LH sign-extend; LBU/LHU zero-extend. Non-load -> load_data 0.
//  - Stores force mem_wb_regWrite=0 regardless of input.
//  - rst (any state, incl. mid-WAIT): FSM IDLE, counter 0, dmem_req 0, all mem_wb_* 0, dmem_timeout 0. Late ack after reset ignored.
// CONFIGURATION
//  - MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]!=0, LW/SW with a[1:0]!=0 -> no dmem_req, no stall, 1-cycle misalign_exc out pulse, bubble to MEM/WB, mem_wb_badaddr (out 32) holds address until next trap/reset.
//  - Not defined: low address bits ignored per size (half uses a[1], word uses none); access proceeds normally; misalign_exc/mem_wb_badaddr ports absent.
// STRUCTURE
//  - Package rv_mem_pkg: opcode constants OP_LOAD/OP_STORE, funct3 size codes, mem_to_reg encodings, FSM state enum.
//  - Sub-module lsu_align: combinational store lane/be generation and load extract/extension; FSM, counter and MEM/WB register live in top.
// TESTING
//  - SB addr 0x1003, rs2 0x000000AB, ack same cycle -> be=1000, wdata=0xABABABAB, no stall, mem_wb_regWrite=0.
//  - LB addr 0x2001, rdata 0x12348078 -> mem_wb_load_data=0xFFFFFF80. LBU same -> 0x00000080.
//  - LHU addr 0x2002, rdata 0xBEEF0000 -> 0x0000BEEF. LH -> 0xFFFFBEEF.
//  - LW with ack after 3 cycles -> mem_stall high 3 cycles, 3 bubbles, then load retires with rdata.
//  - ACK_TIMEOUT=4, ack never -> stall 4 cycles, dmem_timeout pulse, req drops, bubble retired.
//  - rst asserted in WAIT, then ack arrives -> all outputs 0, ack ignored. With MEM_MISALIGN_TRAP_EN: LW 0x1002 -> no req, misalign_exc=1, badaddr=0x1002.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: opcode, access-size, writeback-select and FSM encodings shared by the memory stage
package rv_mem_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_LOAD = 2'b01;
    localparam logic [1:0] M2R_PC4  = 2'b10;
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane/byte-enable generation and load lane extract with sign/zero extension
//   funct3     in  3   access size (bits 1:0) and unsigned flag (bit 2)
//   addr_lo    in  2   low effective-address bits selecting the lane
//   store_data in  32  rs2 store value
//   rdata      in  32  read word from data memory
//   be         out 4   byte enables
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  extracted and extended load value
import rv_mem_pkg::*;

module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [1:0]  size;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic        sx;
    always_comb begin
        size      = funct3[1:0];
        sx        = ~funct3[2];
        lb        = rdata[{addr_lo, 3'b000} +: 8];
        lh        = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be        = size == SZ_B ? 4'b0001 << addr_lo :
                    size == SZ_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata     = size == SZ_B ? {4{store_data[7:0]}} :
                    size == SZ_H ? {2{store_data[15:0]}} : store_data;
        load_data = size == SZ_B ? {{24{sx & lb[7]}}, lb} :
                    size == SZ_H ? {{16{sx & lh[15]}}, lh} : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory stage - dmem req/ack handshake with timeout, upstream stall, MEM/WB register
//   clk, rst (async, active-high)
//   ex_mem_*   in   EX/MEM register outputs (instr, ALUOut, rs2_data, pc, mem_to_reg, regWrite, rd)
//   dmem_*     out  req/we/addr/be/wdata held stable until dmem_ack; dmem_ack/dmem_rdata in
//   mem_stall  out  holds EX/MEM and earlier stages while an access is outstanding
//   dmem_timeout out one-cycle pulse when an access is aborted after ACK_TIMEOUT cycles
//   mem_wb_*   out  MEM/WB register
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap (misalign_exc, mem_wb_badaddr)
import rv_mem_pkg::*;

module mem_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     ex_mem_instr,
    input  logic [XLEN-1:0] ex_mem_ALUOut,
    input  logic [XLEN-1:0] ex_mem_rs2_data,
    input  logic [XLEN-1:0] ex_mem_pc,
    input  logic [1:0]      ex_mem_mem_to_reg,
    input  logic            ex_mem_regWrite,
    input  logic [4:0]      ex_mem_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            dmem_timeout,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            misalign_exc,
    output logic [XLEN-1:0] mem_wb_badaddr,
`endif
    output logic [XLEN-1:0] mem_wb_alu_out,
    output logic [XLEN-1:0] mem_wb_load_data,
    output logic [XLEN-1:0] mem_wb_pc,
    output logic [1:0]      mem_wb_mem_to_reg,
    output logic            mem_wb_regWrite,
    output logic [4:0]      mem_wb_rd
);
    localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_load, is_store, misalign, access, timeout, bubble;
    logic [3:0]      be;
    logic [XLEN-1:0] load_ext;
    logic            unused_instr;
    assign unused_instr = ^{ex_mem_instr[31:15], ex_mem_instr[11:7]};
    lsu_align u_align (
        .funct3     (ex_mem_instr[14:12]),
        .addr_lo    (ex_mem_ALUOut[1:0]),
        .store_data (ex_mem_rs2_data),
        .rdata      (dmem_rdata),
        .be         (be),
        .wdata      (dmem_wdata),
        .load_data  (load_ext)
    );
    always_comb begin
        is_load      = ex_mem_instr[6:0] == OP_LOAD;
        is_store     = ex_mem_instr[6:0] == OP_STORE;
`ifdef MEM_MISALIGN_TRAP_EN
        // funct3[1] marks a word access, funct3[0] a half access
        misalign     = (is_load | is_store) & ~rst &
                       (ex_mem_instr[13] ? |ex_mem_ALUOut[1:0] : ex_mem_instr[12] & ex_mem_ALUOut[0]);
        misalign_exc = misalign;
`else
        misalign     = 1'b0;
`endif
        // reset kills the request combinationally so a mid-WAIT reset drops req at once
        access       = (is_load | is_store) & ~misalign & ~rst;
        // an ack arriving in the final WAIT cycle still wins over the abort
        timeout      = ACK_TIMEOUT != 0 && state == S_WAIT && !dmem_ack && cnt == CW'(ACK_TIMEOUT - 1);
        dmem_req     = access & ~timeout;
        mem_stall    = dmem_req & ~dmem_ack;
        dmem_timeout = timeout;
        bubble       = mem_stall | timeout | misalign;
        dmem_we      = dmem_req & is_store;
        dmem_be      = dmem_req ? be : 4'b0000;
        dmem_addr    = {ex_mem_ALUOut[XLEN-1:2], 2'b00};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            mem_wb_alu_out    <= '0;
            mem_wb_load_data  <= '0;
            mem_wb_pc         <= '0;
            mem_wb_mem_to_reg <= '0;
            mem_wb_regWrite   <= 1'b0;
            mem_wb_rd         <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_wb_badaddr    <= '0;
`endif
        end else begin
            state             <= mem_stall ? S_WAIT : S_IDLE;
            cnt               <= state == S_WAIT && mem_stall ? cnt + 1'b1 : '0;
            mem_wb_alu_out    <= bubble ? '0 : ex_mem_ALUOut;
            mem_wb_load_data  <= bubble || !is_load ? '0 : load_ext;
            mem_wb_pc         <= bubble ? '0 : ex_mem_pc;
            mem_wb_mem_to_reg <= bubble ? '0 : ex_mem_mem_to_reg;
            mem_wb_regWrite   <= !bubble && ex_mem_regWrite && !is_store;
            mem_wb_rd         <= bubble ? '0 : ex_mem_rd;
`ifdef MEM_MISALIGN_TRAP_EN
            if (misalign) mem_wb_badaddr <= ex_mem_ALUOut;
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu (ACK_TIMEOUT=4)
module tb_mem_stage_lsu;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] instr, alu, rs2, pc, rdata;
    logic [1:0]  m2r;
    logic        rw, ack;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we, mem_stall, dmem_timeout, mem_wb_regWrite;
    logic [31:0] dmem_addr, dmem_wdata, mem_wb_alu_out, mem_wb_load_data, mem_wb_pc;
    logic [3:0]  dmem_be;
    logic [1:0]  mem_wb_mem_to_reg;
    logic [4:0]  mem_wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc;
    logic [31:0] mem_wb_badaddr;
`endif
    integer checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_instr(instr), .ex_mem_ALUOut(alu), .ex_mem_rs2_data(rs2), .ex_mem_pc(pc),
        .ex_mem_mem_to_reg(m2r), .ex_mem_regWrite(rw), .ex_mem_rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(ack), .dmem_rdata(rdata),
        .mem_stall(mem_stall), .dmem_timeout(dmem_timeout),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_exc(misalign_exc), .mem_wb_badaddr(mem_wb_badaddr),
`endif
        .mem_wb_alu_out(mem_wb_alu_out), .mem_wb_load_data(mem_wb_load_data), .mem_wb_pc(mem_wb_pc),
        .mem_wb_mem_to_reg(mem_wb_mem_to_reg), .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd)
    );

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] m, input logic w, input logic [4:0] r);
        instr = i; alu = a; rs2 = d; m2r = m; rw = w; rd = r; pc = a + 32'h100;
    endtask

    task automatic test_reset;
        drive(32'h13, 0, 0, 2'b00, 1'b0, 5'd0);
        ack = 1'b0; rdata = 32'h0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall, dmem_timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000", {dmem_req, mem_stall, dmem_timeout});
        end
        checks++;
        if ({mem_wb_alu_out, mem_wb_load_data, mem_wb_pc, mem_wb_mem_to_reg, mem_wb_regWrite, mem_wb_rd} !== 104'd0) begin
            errors++; $display("FAIL reset_mem_wb not zero rd=%0d rw=%b alu=%h", mem_wb_rd, mem_wb_regWrite, mem_wb_alu_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stores;
        logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] ad [3] = '{32'h1003, 32'h1002, 32'h1000};
        logic [31:0] d  [3] = '{32'h000000AB, 32'hCAFE1234, 32'hDEADBEEF};
        logic [3:0]  eb [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] ew [3] = '{32'hABABABAB, 32'h12341234, 32'hDEADBEEF};
        for (int i = 0; i < 3; i++) begin
            drive(mk(f3[i], 7'b0100011), ad[i], d[i], 2'b00, 1'b1, 5'd5);
            ack = 1'b1;
            @(negedge clk);
            checks++;
            if ({dmem_req, dmem_we, mem_stall} !== 3'b110) begin
                errors++; $display("FAIL store%0d_ctrl got %b exp 110", i, {dmem_req, dmem_we, mem_stall});
            end
            checks++;
            if (dmem_be !== eb[i]) begin errors++; $display("FAIL store%0d_be got %b exp %b", i, dmem_be, eb[i]); end
            checks++;
            if (dmem_wdata !== ew[i]) begin errors++; $display("FAIL store%0d_wdata got %h exp %h", i, dmem_wdata, ew[i]); end
            checks++;
            if (dmem_addr !== {ad[i][31:2], 2'b00}) begin
                errors++; $display("FAIL store%0d_addr got %h exp %h", i, dmem_addr, {ad[i][31:2], 2'b00});
            end
            @(posedge clk); #1;
            checks++;
            if (mem_wb_regWrite !== 1'b0 || mem_wb_alu_out !== ad[i]) begin
                errors++; $display("FAIL store%0d_wb got rw=%b alu=%h exp rw=0 alu=%h", i, mem_wb_regWrite, mem_wb_alu_out, ad[i]);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_loads;
        logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] ad [5] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2004};
        logic [31:0] rv [5] = '{32'h12348078, 32'h12348078, 32'hBEEF0000, 32'hBEEF0000, 32'hCAFEF00D};
        logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFFBEEF, 32'hCAFEF00D};
        for (int i = 0; i < 5; i++) begin
            drive(mk(f3[i], 7'b0000011), ad[i], 32'h0, 2'b01, 1'b1, 5'(10 + i));
            ack = 1'b1; rdata = rv[i];
            @(negedge clk);
            checks++;
            if ({dmem_req, dmem_we, mem_stall} !== 3'b100) begin
                errors++; $display("FAIL load%0d_ctrl got %b exp 100", i, {dmem_req, dmem_we, mem_stall});
            end
            @(posedge clk); #1;
            checks++;
            if (mem_wb_load_data !== ex[i]) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, mem_wb_load_data, ex[i]); end
            checks++;
            if ({mem_wb_regWrite, mem_wb_rd, mem_wb_mem_to_reg} !== {1'b1, 5'(10 + i), 2'b01}) begin
                errors++; $display("FAIL load%0d_wb got rw=%b rd=%0d m2r=%b", i, mem_wb_regWrite, mem_wb_rd, mem_wb_mem_to_reg);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_wait_ack;
        drive(mk(3'b010, 7'b0000011), 32'h3000, 32'h0, 2'b01, 1'b1, 5'd9);
        ack = 1'b0; rdata = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dmem_req, mem_stall} !== 2'b11 || dmem_addr !== 32'h3000) begin
                errors++; $display("FAIL wait%0d_stall got req=%b stall=%b addr=%h exp 1 1 3000", i, dmem_req, mem_stall, dmem_addr);
            end
            @(posedge clk); #1;
            checks++;
            if ({mem_wb_regWrite, mem_wb_rd} !== 6'd0) begin
                errors++; $display("FAIL wait%0d_bubble got rw=%b rd=%0d exp 0 0", i, mem_wb_regWrite, mem_wb_rd);
            end
        end
        ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall} !== 2'b10) begin errors++; $display("FAIL wait_ack_ctrl got %b exp 10", {dmem_req, mem_stall}); end
        @(posedge clk); #1;
        checks++;
        if (mem_wb_load_data !== 32'h11223344 || mem_wb_regWrite !== 1'b1 || mem_wb_rd !== 5'd9) begin
            errors++; $display("FAIL wait_retire got data=%h rw=%b rd=%0d exp 11223344 1 9", mem_wb_load_data, mem_wb_regWrite, mem_wb_rd);
        end
        ack = 1'b0;
        drive(32'h13, 0, 0, 2'b00, 1'b0, 5'd0);
    endtask

    task automatic test_timeout;
        drive(mk(3'b010, 7'b0000011), 32'h5000, 32'h0, 2'b01, 1'b1, 5'd6);
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({dmem_req, mem_stall, dmem_timeout} !== 3'b110) begin
                errors++; $display("FAIL tmo_cycle%0d got req/stall/tmo=%b exp 110", i, {dmem_req, mem_stall, dmem_timeout});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall, dmem_timeout} !== 3'b001) begin
            errors++; $display("FAIL tmo_abort got req/stall/tmo=%b exp 001", {dmem_req, mem_stall, dmem_timeout});
        end
        @(posedge clk); #1;
        checks++;
        if ({mem_wb_regWrite, mem_wb_rd, mem_wb_load_data} !== 38'd0) begin
            errors++; $display("FAIL tmo_bubble got rw=%b rd=%0d data=%h exp 0", mem_wb_regWrite, mem_wb_rd, mem_wb_load_data);
        end
        drive(32'h13, 0, 0, 2'b00, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width got %b exp 0", dmem_timeout); end
        @(posedge clk); #1;
    endtask

    task automatic test_non_mem;
        drive(32'h00000013, 32'h55, 32'h0, 2'b00, 1'b1, 5'd7);
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall} !== 2'b00) begin errors++; $display("FAIL alu_ctrl got %b exp 00", {dmem_req, mem_stall}); end
        @(posedge clk); #1;
        checks++;
        if (mem_wb_alu_out !== 32'h55 || mem_wb_load_data !== 32'h0 || mem_wb_regWrite !== 1'b1 || mem_wb_rd !== 5'd7) begin
            errors++; $display("FAIL alu_wb got alu=%h ld=%h rw=%b rd=%0d exp 55 0 1 7", mem_wb_alu_out, mem_wb_load_data, mem_wb_regWrite, mem_wb_rd);
        end
        drive(32'h0000006F, 32'h800, 32'h0, 2'b10, 1'b1, 5'd1);
        @(posedge clk); #1;
        checks++;
        if (mem_wb_pc !== 32'h900 || mem_wb_mem_to_reg !== 2'b10) begin
            errors++; $display("FAIL jal_wb got pc=%h m2r=%b exp 900 10", mem_wb_pc, mem_wb_mem_to_reg);
        end
    endtask

    task automatic test_reset_mid_wait;
        drive(mk(3'b010, 7'b0000011), 32'h4000, 32'h0, 2'b01, 1'b1, 5'd3);
        ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dmem_req, mem_stall, dmem_timeout} !== 3'b000) begin
            errors++; $display("FAIL rstwait_ctrl got %b exp 000", {dmem_req, mem_stall, dmem_timeout});
        end
        drive(32'h13, 0, 0, 2'b00, 1'b0, 5'd0);
        pc = 32'h0;
        @(negedge clk);
        rst = 1'b0; ack = 1'b1; rdata = 32'hFFFFFFFF;
        #1;
        checks++;
        if ({dmem_req, mem_stall} !== 2'b00) begin errors++; $display("FAIL rstwait_late_ack got %b exp 00", {dmem_req, mem_stall}); end
        @(posedge clk); #1;
        checks++;
        if ({mem_wb_alu_out, mem_wb_load_data, mem_wb_pc, mem_wb_mem_to_reg, mem_wb_regWrite, mem_wb_rd} !== 104'd0) begin
            errors++; $display("FAIL rstwait_mem_wb got ld=%h rw=%b rd=%0d exp 0", mem_wb_load_data, mem_wb_regWrite, mem_wb_rd);
        end
        ack = 1'b0;
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign;
        drive(mk(3'b010, 7'b0000011), 32'h1002, 32'h0, 2'b01, 1'b1, 5'd4);
        ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall, misalign_exc} !== 3'b001) begin
            errors++; $display("FAIL mis_ctrl got req/stall/exc=%b exp 001", {dmem_req, mem_stall, misalign_exc});
        end
        @(posedge clk); #1;
        checks++;
        if (mem_wb_badaddr !== 32'h1002 || mem_wb_regWrite !== 1'b0) begin
            errors++; $display("FAIL mis_wb got bad=%h rw=%b exp 1002 0", mem_wb_badaddr, mem_wb_regWrite);
        end
        drive(mk(3'b010, 7'b0000011), 32'h1004, 32'h0, 2'b01, 1'b1, 5'd4);
        ack = 1'b1; rdata = 32'h0BADF00D;
        @(negedge clk);
        checks++;
        if ({dmem_req, misalign_exc} !== 2'b10) begin errors++; $display("FAIL mis_aligned_ctrl got %b exp 10", {dmem_req, misalign_exc}); end
        @(posedge clk); #1;
        checks++;
        if (mem_wb_badaddr !== 32'h1002 || mem_wb_load_data !== 32'h0BADF00D) begin
            errors++; $display("FAIL mis_hold got bad=%h ld=%h exp 1002 0badf00d", mem_wb_badaddr, mem_wb_load_data);
        end
        ack = 1'b0;
    endtask
`else
    task automatic test_low_bits_ignored;
        drive(mk(3'b001, 7'b0000011), 32'h2003, 32'h0, 2'b01, 1'b1, 5'd8);
        ack = 1'b1; rdata = 32'hBEEF0000;
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall} !== 2'b10) begin errors++; $display("FAIL lh_odd_ctrl got %b exp 10", {dmem_req, mem_stall}); end
        @(posedge clk); #1;
        checks++;
        if (mem_wb_load_data !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_odd_data got %h exp ffffbeef", mem_wb_load_data); end
        drive(mk(3'b010, 7'b0100011), 32'h1003, 32'h01020304, 2'b00, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (dmem_be !== 4'b1111 || dmem_addr !== 32'h1000 || dmem_wdata !== 32'h01020304) begin
            errors++; $display("FAIL sw_odd got be=%b addr=%h wd=%h exp 1111 1000 01020304", dmem_be, dmem_addr, dmem_wdata);
        end
        @(posedge clk); #1;
        ack = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_stores;
        test_loads;
        test_wait_ack;
        test_timeout;
        test_non_mem;
        test_reset_mid_wait;
        test_timeout;
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign;
`else
        test_low_bits_ignored;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
